// File: rtl/lfsr_pattern_gen.sv
// Parametrised Fibonacci LFSR pattern generator with timer-paced or STEP-paced stepping,
// runtime seed load, all-zero lockup recovery, step strobe, wrap flag and step counter.
module lfsr_pattern_gen #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] TAPS        = 16'hB400,
   parameter logic [WIDTH-1:0] SEED        = 16'h8000,
   parameter int               FIRST_DLY   = 5,
   parameter int               STEP_PERIOD = 4,
   parameter int               CNTW        = 16
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             EN,
   input  logic             MODE,
   input  logic             STEP,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] SEED_IN,
   output logic [WIDTH-1:0] OUT,
   output logic             STEP_STB,
   output logic             WRAP,
   output logic [CNTW-1:0]  STEP_CNT
);

   localparam int MAX_DLY = (FIRST_DLY > STEP_PERIOD) ? FIRST_DLY : STEP_PERIOD;
   localparam int TW      = $clog2(MAX_DLY) + 1;

   localparam logic [TW-1:0] FIRST_LAST  = TW'(FIRST_DLY - 1);
   localparam logic [TW-1:0] PERIOD_LAST = TW'(STEP_PERIOD - 1);

   localparam logic [0:0] PH_PRIME = 1'b0;
   localparam logic [0:0] PH_RUN   = 1'b1;

   logic [TW-1:0]    timer, timer_d;
   logic [0:0]       phase, phase_d;
   logic [WIDTH-1:0] active_seed;
   logic [WIDTH-1:0] shifted, step_val, seed_eff;
   logic             do_step;

   // A zero successor would lock the register forever, so it is replaced by SEED.
   assign shifted  = {OUT[WIDTH-2:0], ^(OUT & TAPS)};
   assign step_val = (shifted == '0) ? SEED : shifted;
   assign seed_eff = (SEED_IN == '0) ? SEED : SEED_IN;

   always_comb begin
      timer_d = timer;
      phase_d = phase;
      do_step = 1'b0;
      if (LOAD || !EN) begin
         timer_d = '0;
         phase_d = PH_PRIME;
      end else if (MODE) begin
         timer_d = '0;
         phase_d = PH_RUN;
         do_step = STEP;
      end else if (phase == PH_PRIME) begin
         if (timer == FIRST_LAST) begin
            do_step = 1'b1;
            timer_d = '0;
            phase_d = PH_RUN;
         end else begin
            timer_d = timer + 1'b1;
         end
      end else begin
         if (timer == PERIOD_LAST) begin
            do_step = 1'b1;
            timer_d = '0;
         end else begin
            timer_d = timer + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         OUT         <= SEED;
         active_seed <= SEED;
         STEP_STB    <= 1'b0;
         WRAP        <= 1'b0;
         STEP_CNT    <= '0;
         timer       <= '0;
         phase       <= PH_PRIME;
      end else begin
         timer    <= timer_d;
         phase    <= phase_d;
         STEP_STB <= do_step;
         WRAP     <= do_step && (step_val == active_seed);
         if (LOAD) begin
            OUT         <= seed_eff;
            active_seed <= seed_eff;
            STEP_CNT    <= '0;
         end else if (do_step) begin
            OUT      <= step_val;
            STEP_CNT <= STEP_CNT + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Bench for lfsr_pattern_gen: two instances (max-length taps and TAPS=0 for lockup recovery)
// driven in lockstep, with a reference model feeding per-instance expected queues.
module tb_lfsr_pattern_gen;

   localparam logic [15:0] SEED   = 16'h8000;
   localparam int          FIRST  = 5;
   localparam int          PERIOD = 4;
   localparam int          EW     = 65;

   logic        clk = 1'b0;
   logic        rstn;
   logic        en, mode, step, load;
   logic [15:0] seed_in;
   logic [15:0] out_a, out_b, cnt_a, cnt_b;
   logic        stb_a, stb_b, wrap_a, wrap_b;

   lfsr_pattern_gen #(.WIDTH(16), .TAPS(16'hB400), .SEED(SEED), .FIRST_DLY(FIRST),
                      .STEP_PERIOD(PERIOD), .CNTW(16)) dut_a (
      .CLK(clk), .RSTN(rstn), .EN(en), .MODE(mode), .STEP(step), .LOAD(load),
      .SEED_IN(seed_in), .OUT(out_a), .STEP_STB(stb_a), .WRAP(wrap_a), .STEP_CNT(cnt_a));

   lfsr_pattern_gen #(.WIDTH(16), .TAPS(16'h0000), .SEED(SEED), .FIRST_DLY(FIRST),
                      .STEP_PERIOD(PERIOD), .CNTW(16)) dut_b (
      .CLK(clk), .RSTN(rstn), .EN(en), .MODE(mode), .STEP(step), .LOAD(load),
      .SEED_IN(seed_in), .OUT(out_b), .STEP_STB(stb_b), .WRAP(wrap_b), .STEP_CNT(cnt_b));

   // clock / edge numbering
   always #5 clk = ~clk;
   int edge_no = 0;
   always @(posedge clk) edge_no <= edge_no + 1;

   // scoreboard state
   logic [EW-1:0] exp_q_a[$];
   logic [EW-1:0] exp_q_b[$];
   int chk_cnt = 0;
   int pass_cnt = 0;
   int wrap_cnt_a = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
   endtask

   // reference model: steps land at EN-high auto edges FIRST, FIRST+PERIOD, ... since restart
   logic [15:0] m_out[2], m_seed[2], m_cnt[2];
   int          auto_n[2], due[2];
   logic [15:0] m_taps[2] = '{16'hB400, 16'h0000};

   function automatic logic [15:0] ref_next(input logic [15:0] v, input logic [15:0] taps);
      int          ones;
      logic [15:0] n;
      ones = $countones(v & taps);
      n    = (v << 1) | 16'(ones % 2);
      return (n == 16'h0) ? SEED : n;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_out[k] = SEED; m_seed[k] = SEED; m_cnt[k] = 16'h0;
         auto_n[k] = 0; due[k] = FIRST;
      end
      exp_q_a.delete();
      exp_q_b.delete();
   endtask

   task automatic model_step(input int k);
      logic [EW-1:0] e;
      m_out[k] = ref_next(m_out[k], m_taps[k]);
      m_cnt[k] = m_cnt[k] + 16'h1;
      e = {32'(edge_no + 1), (m_out[k] == m_seed[k]), m_out[k], m_cnt[k]};
      if (k == 0) exp_q_a.push_back(e);
      else        exp_q_b.push_back(e);
   endtask

   task automatic model_edge(input logic e_en, e_mode, e_step, e_load, input logic [15:0] e_seed);
      for (int k = 0; k < 2; k++) begin
         if (e_load) begin
            m_out[k]  = (e_seed == 16'h0) ? SEED : e_seed;
            m_seed[k] = m_out[k];
            m_cnt[k]  = 16'h0;
            auto_n[k] = 0; due[k] = FIRST;
         end else if (!e_en) begin
            auto_n[k] = 0; due[k] = FIRST;
         end else if (e_mode) begin
            auto_n[k] = 0; due[k] = PERIOD;
            if (e_step) model_step(k);
         end else begin
            auto_n[k]++;
            if (auto_n[k] == due[k]) begin
               model_step(k);
               due[k] = due[k] + PERIOD;
            end
         end
      end
   endtask

   // driver: apply inputs, predict the coming edge, then advance past it
   task automatic cycle(input logic c_en, c_mode, c_step, c_load, input logic [15:0] c_seed);
      en = c_en; mode = c_mode; step = c_step; load = c_load; seed_in = c_seed;
      model_edge(c_en, c_mode, c_step, c_load, c_seed);
      @(posedge clk);
      #1;
   endtask

   // monitor: pop and compare whenever an instance presents a step strobe
   task automatic mon(input int k, input logic stb, wrap, input logic [15:0] out, cnt);
      logic [EW-1:0] e;
      string         tag;
      tag = (k == 0) ? "a" : "b";
      if (stb) begin
         if ((k == 0 && exp_q_a.size() == 0) || (k == 1 && exp_q_b.size() == 0)) begin
            check({"unexpected_stb_", tag}, 64'h1, 64'h0);
         end else begin
            e = (k == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
            check({"stb_edge_", tag}, 64'(edge_no), 64'(e[64:33]));
            check({"stb_data_", tag}, 64'({wrap, out, cnt}), 64'(e[32:0]));
         end
         if (k == 0 && wrap) wrap_cnt_a++;
      end else begin
         check({"wrap_without_stb_", tag}, 64'(wrap), 64'h0);
      end
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         mon(0, stb_a, wrap_a, out_a, cnt_a);
         mon(1, stb_b, wrap_b, out_b, cnt_b);
      end
   end

   initial begin
      rstn = 1'b0; en = 1'b0; mode = 1'b0; step = 1'b0; load = 1'b0; seed_in = 16'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", 64'(out_a), 64'h8000);
      check("reset_cnt", 64'(cnt_a), 64'h0);
      check("reset_stb", 64'({stb_a, wrap_a}), 64'h0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // auto stepping from reset: edges 5, 9, 13
      repeat (13) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t1_out", 64'(out_a), 64'h0004);
      check("t1_cnt", 64'(cnt_a), 64'h3);

      // zero seed load falls back to SEED; enable gap restarts the first delay
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      check("t4_zero_seed_out", 64'(out_a), 64'h8000);
      check("t4_zero_seed_cnt", 64'(cnt_a), 64'h0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t2_gap_hold", 64'(out_a), 64'h8000);
      repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t2_before_first", 64'(out_a), 64'h8000);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t2_first_step", 64'(out_a), 64'h0001);

      // LOAD beats a simultaneous STEP
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
      check("t4_load_out", 64'(out_a), 64'h1234);
      check("t4_load_cnt", 64'(cnt_a), 64'h0);
      check("t4_load_no_stb", 64'(stb_a), 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

      // TAPS=0 instance: sixteenth step from 0001 would be zero, recovers to SEED
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0001);
      repeat (16) cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      check("t5_lockup_out", 64'(out_b), 64'h8000);
      check("t5_lockup_stb", 64'(stb_b), 64'h1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

      // reset mid-RUN two edges after a step
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      repeat (7) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      #2;
      rstn = 1'b0;
      en = 1'b0;
      #1;
      check("t6_reset_out", 64'(out_a), 64'h8000);
      check("t6_reset_stb", 64'(stb_a), 64'h0);
      check("t6_reset_cnt", 64'(cnt_a), 64'h0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t6_hold_after_reset", 64'(out_a), 64'h8000);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t6_step_at_5", 64'(out_a), 64'h0001);

      // full period in manual mode: exactly one wrap, on step 65535
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      wrap_cnt_a = 0;
      repeat (65535) cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      check("t3_wrap_count", 64'(wrap_cnt_a), 64'h1);
      check("t3_out", 64'(out_a), 64'h8000);
      check("t3_cnt", 64'(cnt_a), 64'hFFFF);

      // randomized mix of enables, modes, steps and loads
      repeat (3000) begin
         logic [15:0] s;
         s = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(0, 16'hFFFF));
         cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0), s);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      check("final_out_a", 64'(out_a), 64'(m_out[0]));
      check("final_cnt_a", 64'(cnt_a), 64'(m_cnt[0]));
      check("final_out_b", 64'(out_b), 64'(m_out[1]));
      check("missing_stb_a", 64'(exp_q_a.size()), 64'h0);
      check("missing_stb_b", 64'(exp_q_b.size()), 64'h0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
